// File: rtl/onset_envelope_decimator.sv
`default_nettype none
// ============================================================================
// Module  : onset_envelope_decimator
// Brief   : peak-hold decimation, moving-average envelope, noise-floor removal
// Revision: 1.0
// ============================================================================
module onset_envelope_decimator #(
  parameter int W              = 16,
  parameter int DECIM          = 6,
  parameter int WIN_LOG2       = 3,
  parameter int ENVELOPE_WIDTH = 24,
  parameter int FLOOR_SHIFT    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] audio_sample,
  input  logic                audio_valid,
  output logic signed [W-1:0] signal_rms,
  output logic                sample_tick,
  output logic        [W-1:0] envelope,
  output logic        [W-1:0] noise_floor
);

  localparam int c_FRAC  = ENVELOPE_WIDTH - W;
  localparam int c_DEPTH = 2**WIN_LOG2;
  localparam int c_PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int c_SW    = W - 1 + WIN_LOG2;
  localparam int c_DW    = ENVELOPE_WIDTH + 1;
  localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(DECIM - 1);

  // Asynchronous assertion, release synchronised to clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [c_PW-1:0]    phase_q, phase_d;
  logic [W-2:0]       peak_q, peak_d, blk_peak_q, blk_peak_d;
  logic               a_vld_q, a_vld_d;
  logic [W-2:0]       win_q [c_DEPTH];
  logic [W-2:0]       win_d [c_DEPTH];
  logic [WIN_LOG2-1:0] wp_q, wp_d;
  logic [c_SW-1:0]    sum_q, sum_d;
  logic               b_vld_q, b_vld_d;
  logic [W-2:0]       fast_env_q, fast_env_d;
  logic               c_vld_q, c_vld_d;
  logic [ENVELOPE_WIDTH-1:0] floor_acc_q, floor_acc_d;
  logic signed [W-1:0] signal_rms_q, signal_rms_d;
  logic               sample_tick_q, sample_tick_d;
  logic [W-1:0]       envelope_q, envelope_d, noise_floor_q, noise_floor_d;

  logic [W-1:0]       neg;
  logic [W-2:0]       mag, peak_max;
  logic signed [c_DW-1:0] env_ext, floor_ext, diff, step;
  logic [W-1:0]       floor_int;

  // Stage A: magnitude and peak hold over one block of DECIM strobes.
  always_comb begin
    neg        = -audio_sample;
    mag        = audio_sample[W-2:0];
    phase_d    = phase_q;
    peak_d     = peak_q;
    blk_peak_d = blk_peak_q;
    a_vld_d    = 1'b0;
    if (audio_sample == {1'b1, {(W-1){1'b0}}}) mag = '1;
    else if (audio_sample[W-1])                mag = (W-1)'(neg);
    peak_max = (mag > peak_q) ? mag : peak_q;
    if (audio_valid) begin
      if (phase_q == c_PHASE_LAST) begin
        blk_peak_d = peak_max;
        peak_d     = '0;
        phase_d    = '0;
        a_vld_d    = 1'b1;
      end else begin
        peak_d  = peak_max;
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Stage B: running sum over a circular window of block peaks.
  always_comb begin
    win_d   = win_q;
    wp_d    = wp_q;
    sum_d   = sum_q;
    b_vld_d = a_vld_q;
    if (a_vld_q) begin
      sum_d       = sum_q + c_SW'(blk_peak_q) - c_SW'(win_q[wp_q]);
      win_d[wp_q] = blk_peak_q;
      wp_d        = wp_q + 1'b1;
    end
  end

  // Stage C: register the mean, then subtract the pre-update floor and leak it.
  always_comb begin
    fast_env_d    = fast_env_q;
    c_vld_d       = b_vld_q;
    floor_acc_d   = floor_acc_q;
    signal_rms_d  = signal_rms_q;
    envelope_d    = envelope_q;
    noise_floor_d = noise_floor_q;
    sample_tick_d = c_vld_q;
    env_ext   = {{(c_DW - (W-1) - c_FRAC){1'b0}}, fast_env_q, {c_FRAC{1'b0}}};
    floor_ext = {1'b0, floor_acc_q};
    diff      = env_ext - floor_ext;
    step      = diff >>> FLOOR_SHIFT;
    floor_int = floor_acc_q[ENVELOPE_WIDTH-1:c_FRAC];
    if (b_vld_q) fast_env_d = sum_q[c_SW-1:WIN_LOG2];
    if (c_vld_q) begin
      signal_rms_d  = $signed({1'b0, fast_env_q}) - $signed(floor_int);
      floor_acc_d   = floor_acc_q + ENVELOPE_WIDTH'(step);
      envelope_d    = {1'b0, fast_env_q};
      noise_floor_d = floor_int;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= '0;
      peak_q        <= '0;
      blk_peak_q    <= '0;
      a_vld_q       <= 1'b0;
      win_q         <= '{default: '0};
      wp_q          <= '0;
      sum_q         <= '0;
      b_vld_q       <= 1'b0;
      fast_env_q    <= '0;
      c_vld_q       <= 1'b0;
      floor_acc_q   <= '0;
      signal_rms_q  <= '0;
      sample_tick_q <= 1'b0;
      envelope_q    <= '0;
      noise_floor_q <= '0;
    end else begin
      phase_q       <= phase_d;
      peak_q        <= peak_d;
      blk_peak_q    <= blk_peak_d;
      a_vld_q       <= a_vld_d;
      win_q         <= win_d;
      wp_q          <= wp_d;
      sum_q         <= sum_d;
      b_vld_q       <= b_vld_d;
      fast_env_q    <= fast_env_d;
      c_vld_q       <= c_vld_d;
      floor_acc_q   <= floor_acc_d;
      signal_rms_q  <= signal_rms_d;
      sample_tick_q <= sample_tick_d;
      envelope_q    <= envelope_d;
      noise_floor_q <= noise_floor_d;
    end
  end

  assign signal_rms  = signal_rms_q;
  assign sample_tick = sample_tick_q;
  assign envelope    = envelope_q;
  assign noise_floor = noise_floor_q;

endmodule
`default_nettype wire
